// File: rtl/spi_arb_pkg.sv
// Shared types and default widths for the SPI transfer arbiter.
package spi_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 8;
  localparam int unsigned DEF_NSS_NUM    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [LOG_NUM_REQ-1:0] ptr,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [LOG_NUM_REQ-1:0] idx,
  output logic                   valid
);

  logic [LOG_NUM_REQ-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = LOG_NUM_REQ'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arb.sv
// Round-robin scheduler sharing one SPI transfer engine among NUM_REQ requesters.
module spi_xfer_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ),
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned NSS_NUM     = DEF_NSS_NUM
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*NSS_NUM-1:0]      req_nss_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]    req_txcnt_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]    req_rxcnt_i,
  input  logic [NUM_REQ-1:0]              tx_valid_i,
  output logic [NUM_REQ-1:0]              tx_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   tx_data_i,
  output logic [NUM_REQ-1:0]              rx_valid_o,
  input  logic [NUM_REQ-1:0]              rx_ready_i,
  output logic [DATA_WIDTH-1:0]           rx_data_o,
  output logic                            core_start_o,
  output logic [NSS_NUM-1:0]              core_nss_o,
  output logic                            core_tx_valid_o,
  input  logic                            core_tx_ready_i,
  output logic [DATA_WIDTH-1:0]           core_tx_data_o,
  input  logic                            core_rx_valid_i,
  output logic                            core_rx_ready_o,
  input  logic [DATA_WIDTH-1:0]           core_rx_data_i,
  input  logic                            core_done_i,
  output logic [LOG_NUM_REQ-1:0]          gnt_idx_o,
  output logic                            busy_o
);

  state_e                 state_q, state_d;
  logic [LOG_NUM_REQ-1:0] gnt_q, gnt_d;
  logic [LOG_NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   tx_left_q, tx_left_d;
  logic [CNT_WIDTH-1:0]   rx_left_q, rx_left_d;
  logic [NSS_NUM-1:0]     nss_q, nss_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [LOG_NUM_REQ-1:0] arb_idx;
  logic                   arb_valid;
  logic [CNT_WIDTH-1:0]   arb_txcnt;
  logic [CNT_WIDTH-1:0]   arb_rxcnt;

  rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign arb_txcnt = req_txcnt_i[32'(arb_idx)*CNT_WIDTH +: CNT_WIDTH];
  assign arb_rxcnt = req_rxcnt_i[32'(arb_idx)*CNT_WIDTH +: CNT_WIDTH];

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      tx_left_q <= '0;
      rx_left_q <= '0;
      nss_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      tx_left_q <= tx_left_d;
      rx_left_q <= rx_left_d;
      nss_q     <= nss_d;
    end
  end

  // Next-state, counters and word-stream steering
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    rr_ptr_d        = rr_ptr_q;
    tx_left_d       = tx_left_q;
    rx_left_d       = rx_left_q;
    nss_d           = nss_q;
    req_ready_o     = '0;
    tx_ready_o      = '0;
    rx_valid_o      = '0;
    rx_data_o       = '0;
    core_tx_valid_o = 1'b0;
    core_tx_data_o  = '0;
    core_rx_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        nss_d = '0;
        if (arb_valid) begin
          req_ready_o = arb_gnt;
          gnt_d       = arb_idx;
          tx_left_d   = arb_txcnt;
          rx_left_d   = arb_rxcnt;
          rr_ptr_d    = (arb_idx == LOG_NUM_REQ'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          // Zero-length descriptors are consumed without touching the engine
          if (arb_txcnt != '0 || arb_rxcnt != '0) begin
            nss_d   = req_nss_i[32'(arb_idx)*NSS_NUM +: NSS_NUM];
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        state_d = ST_XFER;
      end

      ST_XFER: begin
        if (tx_left_q != '0) begin
          core_tx_valid_o   = tx_valid_i[gnt_q];
          core_tx_data_o    = tx_data_i[32'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
          tx_ready_o[gnt_q] = core_tx_ready_i;
          if (tx_valid_i[gnt_q] && core_tx_ready_i) begin
            tx_left_d = tx_left_q - 1'b1;
          end
        end
        if (rx_left_q != '0) begin
          rx_valid_o[gnt_q] = core_rx_valid_i;
          rx_data_o         = core_rx_data_i;
          core_rx_ready_o   = rx_ready_i[gnt_q];
          if (core_rx_valid_i && rx_ready_i[gnt_q]) begin
            rx_left_d = rx_left_q - 1'b1;
          end
        end else begin
          core_rx_ready_o = 1'b1;
        end
        // Done with words still outstanding truncates the transaction
        if (core_done_i) begin
          state_d   = ST_IDLE;
          tx_left_d = '0;
          rx_left_d = '0;
          nss_d     = '0;
        end else if (tx_left_d == '0 && rx_left_d == '0) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        core_rx_ready_o = 1'b1;
        if (core_done_i) begin
          state_d = ST_IDLE;
          nss_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        nss_d   = '0;
      end
    endcase
  end

  assign core_start_o = (state_q == ST_START);
  assign core_nss_o   = nss_q;
  assign gnt_idx_o    = gnt_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Directed self-checking bench for spi_xfer_arb.
module tb_spi_xfer_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned LN  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned NSS = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*NSS-1:0]  req_nss_i;
  logic [N*CW-1:0]   req_txcnt_i;
  logic [N*CW-1:0]   req_rxcnt_i;
  logic [N-1:0]      tx_valid_i;
  logic [N-1:0]      tx_ready_o;
  logic [N*DW-1:0]   tx_data_i;
  logic [N-1:0]      rx_valid_o;
  logic [N-1:0]      rx_ready_i;
  logic [DW-1:0]     rx_data_o;
  logic              core_start_o;
  logic [NSS-1:0]    core_nss_o;
  logic              core_tx_valid_o;
  logic              core_tx_ready_i;
  logic [DW-1:0]     core_tx_data_o;
  logic              core_rx_valid_i;
  logic              core_rx_ready_o;
  logic [DW-1:0]     core_rx_data_i;
  logic              core_done_i;
  logic [LN-1:0]     gnt_idx_o;
  logic              busy_o;

  int vecs = 0;
  int errs = 0;

  spi_xfer_arb dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_nss_i       (req_nss_i),
    .req_txcnt_i     (req_txcnt_i),
    .req_rxcnt_i     (req_rxcnt_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .tx_data_i       (tx_data_i),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .rx_data_o       (rx_data_o),
    .core_start_o    (core_start_o),
    .core_nss_o      (core_nss_o),
    .core_tx_valid_o (core_tx_valid_o),
    .core_tx_ready_i (core_tx_ready_i),
    .core_tx_data_o  (core_tx_data_o),
    .core_rx_valid_i (core_rx_valid_i),
    .core_rx_ready_o (core_rx_ready_o),
    .core_rx_data_i  (core_rx_data_i),
    .core_done_i     (core_done_i),
    .gnt_idx_o       (gnt_idx_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_desc(input int i, input logic v, input logic [NSS-1:0] nss,
                          input logic [CW-1:0] txc, input logic [CW-1:0] rxc);
    req_valid_i[i]           = v;
    req_nss_i[i*NSS +: NSS]  = nss;
    req_txcnt_i[i*CW +: CW]  = txc;
    req_rxcnt_i[i*CW +: CW]  = rxc;
  endtask

  task automatic test_reset;
    @(negedge clk_i); #1;
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vecs++; if (core_nss_o !== 4'b0000) begin errs++; $display("FAIL reset_nss got %b want 0000", core_nss_o); end
    vecs++; if (gnt_idx_o !== 2'd0) begin errs++; $display("FAIL reset_gnt got %0d want 0", gnt_idx_o); end
    vecs++; if (core_start_o !== 1'b0) begin errs++; $display("FAIL reset_start got %b want 0", core_start_o); end
    vecs++; if (req_ready_o !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got %b want 0000", req_ready_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk_i); set_desc(0, 1'b1, 4'b0001, 8'd2, 8'd2); #1;
    vecs++; if (req_ready_o !== 4'b0001) begin errs++; $display("FAIL single_req_ready got %b want 0001", req_ready_o); end
    vecs++; if (core_start_o !== 1'b0) begin errs++; $display("FAIL single_start_early got %b want 0", core_start_o); end
    @(negedge clk_i); req_valid_i[0] = 1'b0; #1;
    vecs++; if (core_start_o !== 1'b1) begin errs++; $display("FAIL single_start got %b want 1", core_start_o); end
    vecs++; if (core_nss_o !== 4'b0001) begin errs++; $display("FAIL single_nss got %b want 0001", core_nss_o); end
    @(negedge clk_i); tx_valid_i[0] = 1'b1; tx_data_i[31:0] = 32'hA5A5A5A5; core_tx_ready_i = 1'b1; #1;
    vecs++; if (core_start_o !== 1'b0) begin errs++; $display("FAIL single_start_width got %b want 0", core_start_o); end
    vecs++; if (tx_ready_o !== 4'b0001) begin errs++; $display("FAIL single_tx_ready got %b want 0001", tx_ready_o); end
    vecs++; if (core_tx_data_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL single_tx_d0 got %h want a5a5a5a5", core_tx_data_o); end
    @(negedge clk_i); tx_data_i[31:0] = 32'h12345678; #1;
    vecs++; if (core_tx_data_o !== 32'h12345678) begin errs++; $display("FAIL single_tx_d1 got %h want 12345678", core_tx_data_o); end
    @(negedge clk_i); core_rx_valid_i = 1'b1; core_rx_data_i = 32'hA5A5A5A5; rx_ready_i[0] = 1'b1; #1;
    vecs++; if (core_tx_valid_o !== 1'b0 || tx_ready_o !== 4'b0000) begin errs++; $display("FAIL single_tx_exhausted got v=%b r=%b want 0/0000", core_tx_valid_o, tx_ready_o); end
    vecs++; if (rx_valid_o !== 4'b0001 || rx_data_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL single_rx_d0 got %b/%h want 0001/a5a5a5a5", rx_valid_o, rx_data_o); end
    @(negedge clk_i); core_rx_data_i = 32'h12345678; #1;
    vecs++; if (rx_valid_o !== 4'b0001 || rx_data_o !== 32'h12345678) begin errs++; $display("FAIL single_rx_d1 got %b/%h want 0001/12345678", rx_valid_o, rx_data_o); end
    @(negedge clk_i);
    tx_valid_i = '0; core_tx_ready_i = 1'b0; core_rx_valid_i = 1'b0; rx_ready_i = '0; core_done_i = 1'b1; #1;
    vecs++; if (busy_o !== 1'b1 || rx_valid_o !== 4'b0000) begin errs++; $display("FAIL single_drain got busy=%b rxv=%b want 1/0000", busy_o, rx_valid_o); end
    @(negedge clk_i); core_done_i = 1'b0; #1;
    vecs++; if (busy_o !== 1'b0 || core_nss_o !== 4'b0000) begin errs++; $display("FAIL single_idle got busy=%b nss=%b want 0/0000", busy_o, core_nss_o); end
  endtask

  task automatic test_simultaneous;
    int k;
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    for (int i = 0; i < 4; i++) set_desc(i, 1'b1, 4'(1 << i), 8'd1, 8'd0);
    for (int it = 0; it < 5; it++) begin
      k = it % 4;
      if (it == 4) set_desc(0, 1'b1, 4'b0001, 8'd1, 8'd0);
      #1;
      vecs++; if (req_ready_o !== 4'(1 << k)) begin errs++; $display("FAIL simul_ready[%0d] got %b want %b", it, req_ready_o, 4'(1 << k)); end
      @(negedge clk_i); req_valid_i[k] = 1'b0; #1;
      vecs++; if (core_start_o !== 1'b1 || gnt_idx_o !== 2'(k)) begin errs++; $display("FAIL simul_start[%0d] got start=%b gnt=%0d want 1/%0d", it, core_start_o, gnt_idx_o, k); end
      @(negedge clk_i); tx_valid_i[k] = 1'b1; core_tx_ready_i = 1'b1; #1;
      vecs++; if (tx_ready_o !== 4'(1 << k)) begin errs++; $display("FAIL simul_tx_ready[%0d] got %b want %b", it, tx_ready_o, 4'(1 << k)); end
      @(negedge clk_i); tx_valid_i[k] = 1'b0; core_tx_ready_i = 1'b0; core_done_i = 1'b1; #1;
      vecs++; if (core_start_o !== 1'b0 || busy_o !== 1'b1) begin errs++; $display("FAIL simul_drain[%0d] got start=%b busy=%b want 0/1", it, core_start_o, busy_o); end
      @(negedge clk_i); core_done_i = 1'b0;
    end
  endtask

  task automatic test_zero_len;
    @(negedge clk_i); set_desc(2, 1'b1, 4'b0100, 8'd0, 8'd0); #1;
    vecs++; if (req_ready_o !== 4'b0100) begin errs++; $display("FAIL zero_ready got %b want 0100", req_ready_o); end
    @(negedge clk_i); req_valid_i[2] = 1'b0;
    set_desc(1, 1'b1, 4'b0010, 8'd0, 8'd0); set_desc(3, 1'b1, 4'b1000, 8'd0, 8'd0); #1;
    vecs++; if (core_start_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL zero_no_start got start=%b busy=%b want 0/0", core_start_o, busy_o); end
    vecs++; if (gnt_idx_o !== 2'd2 || core_nss_o !== 4'b0000) begin errs++; $display("FAIL zero_gnt got gnt=%0d nss=%b want 2/0000", gnt_idx_o, core_nss_o); end
    vecs++; if (req_ready_o !== 4'b1000) begin errs++; $display("FAIL zero_rrptr3 got %b want 1000", req_ready_o); end
    @(negedge clk_i); req_valid_i[3] = 1'b0; #1;
    vecs++; if (req_ready_o !== 4'b0010) begin errs++; $display("FAIL zero_wrap got %b want 0010", req_ready_o); end
    @(negedge clk_i); req_valid_i[1] = 1'b0; #1;
    vecs++; if (gnt_idx_o !== 2'd1 || core_start_o !== 1'b0) begin errs++; $display("FAIL zero_second got gnt=%0d start=%b want 1/0", gnt_idx_o, core_start_o); end
  endtask

  task automatic test_surplus;
    @(negedge clk_i); set_desc(2, 1'b1, 4'b0100, 8'd2, 8'd1); #1;
    vecs++; if (req_ready_o !== 4'b0100) begin errs++; $display("FAIL surplus_ready got %b want 0100", req_ready_o); end
    @(negedge clk_i); req_valid_i[2] = 1'b0;
    @(negedge clk_i); core_rx_valid_i = 1'b1; core_rx_data_i = 32'h00000A00; rx_ready_i[2] = 1'b1; #1;
    vecs++; if (rx_valid_o !== 4'b0100 || rx_data_o !== 32'h00000A00) begin errs++; $display("FAIL surplus_fwd got %b/%h want 0100/00000a00", rx_valid_o, rx_data_o); end
    for (int j = 1; j < 3; j++) begin
      @(negedge clk_i); rx_ready_i[2] = 1'b0; core_rx_data_i = 32'h00000A00 + 32'(j); #1;
      vecs++; if (rx_valid_o !== 4'b0000 || core_rx_ready_o !== 1'b1) begin errs++; $display("FAIL surplus_drop[%0d] got rxv=%b rdy=%b want 0000/1", j, rx_valid_o, core_rx_ready_o); end
    end
    @(negedge clk_i); core_rx_valid_i = 1'b0; tx_valid_i[2] = 1'b1; tx_data_i[64 +: 32] = 32'h00000B01; core_tx_ready_i = 1'b1; #1;
    vecs++; if (tx_ready_o !== 4'b0100) begin errs++; $display("FAIL surplus_tx0 got %b want 0100", tx_ready_o); end
    @(negedge clk_i); #1;
    vecs++; if (tx_ready_o !== 4'b0100) begin errs++; $display("FAIL surplus_tx1 got %b want 0100", tx_ready_o); end
    @(negedge clk_i); tx_valid_i[2] = 1'b0; core_tx_ready_i = 1'b0; core_done_i = 1'b1; #1;
    vecs++; if (busy_o !== 1'b1 || tx_ready_o !== 4'b0000) begin errs++; $display("FAIL surplus_drain got busy=%b txr=%b want 1/0000", busy_o, tx_ready_o); end
    @(negedge clk_i); core_done_i = 1'b0; #1;
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL surplus_idle got %b want 0", busy_o); end
  endtask

  task automatic test_truncation;
    @(negedge clk_i); set_desc(3, 1'b1, 4'b1000, 8'd4, 8'd0); #1;
    vecs++; if (req_ready_o !== 4'b1000) begin errs++; $display("FAIL trunc_ready got %b want 1000", req_ready_o); end
    @(negedge clk_i); req_valid_i[3] = 1'b0;
    @(negedge clk_i); tx_valid_i[3] = 1'b1; core_tx_ready_i = 1'b1; #1;
    vecs++; if (tx_ready_o !== 4'b1000) begin errs++; $display("FAIL trunc_tx0 got %b want 1000", tx_ready_o); end
    @(negedge clk_i); core_done_i = 1'b1; #1;
    vecs++; if (tx_ready_o !== 4'b1000) begin errs++; $display("FAIL trunc_tx1 got %b want 1000", tx_ready_o); end
    @(negedge clk_i); core_done_i = 1'b0; #1;
    vecs++; if (tx_ready_o !== 4'b0000 || core_tx_valid_o !== 1'b0) begin errs++; $display("FAIL trunc_no_tx got txr=%b v=%b want 0000/0", tx_ready_o, core_tx_valid_o); end
    vecs++; if (busy_o !== 1'b0 || core_nss_o !== 4'b0000) begin errs++; $display("FAIL trunc_idle got busy=%b nss=%b want 0/0000", busy_o, core_nss_o); end
    @(negedge clk_i); #1;
    vecs++; if (tx_ready_o !== 4'b0000 || core_start_o !== 1'b0) begin errs++; $display("FAIL trunc_stay got txr=%b start=%b want 0000/0", tx_ready_o, core_start_o); end
    tx_valid_i[3] = 1'b0; core_tx_ready_i = 1'b0;
  endtask

  task automatic test_backpressure;
    @(negedge clk_i); set_desc(1, 1'b1, 4'b0010, 8'd0, 8'd2); #1;
    vecs++; if (req_ready_o !== 4'b0010) begin errs++; $display("FAIL bp_ready got %b want 0010", req_ready_o); end
    @(negedge clk_i); req_valid_i[1] = 1'b0;
    @(negedge clk_i); core_rx_valid_i = 1'b1; core_rx_data_i = 32'hCAFE0001; rx_ready_i[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      vecs++; if (core_rx_ready_o !== 1'b0 || rx_valid_o !== 4'b0010 || rx_data_o !== 32'hCAFE0001) begin errs++; $display("FAIL bp_hold[%0d] got rdy=%b rxv=%b d=%h want 0/0010/cafe0001", c, core_rx_ready_o, rx_valid_o, rx_data_o); end
      @(negedge clk_i);
    end
    rx_ready_i[1] = 1'b1; #1;
    vecs++; if (core_rx_ready_o !== 1'b1) begin errs++; $display("FAIL bp_release got %b want 1", core_rx_ready_o); end
    @(negedge clk_i); core_rx_data_i = 32'hCAFE0002; #1;
    vecs++; if (rx_valid_o !== 4'b0010 || rx_data_o !== 32'hCAFE0002) begin errs++; $display("FAIL bp_word2 got %b/%h want 0010/cafe0002", rx_valid_o, rx_data_o); end
    @(negedge clk_i); core_rx_valid_i = 1'b0; rx_ready_i = '0; #1;
    vecs++; if (busy_o !== 1'b1 || rx_valid_o !== 4'b0000) begin errs++; $display("FAIL bp_drain got busy=%b rxv=%b want 1/0000", busy_o, rx_valid_o); end
    core_done_i = 1'b1;
    @(negedge clk_i); core_done_i = 1'b0; #1;
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL bp_idle got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i); set_desc(2, 1'b1, 4'b0100, 8'd5, 8'd5); #1;
    vecs++; if (req_ready_o !== 4'b0100) begin errs++; $display("FAIL rstmid_ready got %b want 0100", req_ready_o); end
    @(negedge clk_i); req_valid_i[2] = 1'b0;
    @(negedge clk_i); tx_valid_i[2] = 1'b1; core_tx_ready_i = 1'b1; #1;
    vecs++; if (tx_ready_o !== 4'b0100) begin errs++; $display("FAIL rstmid_xfer got %b want 0100", tx_ready_o); end
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; tx_valid_i = '0; core_tx_ready_i = 1'b0; #1;
    vecs++; if (busy_o !== 1'b0 || core_nss_o !== 4'b0000 || gnt_idx_o !== 2'd0) begin errs++; $display("FAIL rstmid_state got busy=%b nss=%b gnt=%0d want 0/0000/0", busy_o, core_nss_o, gnt_idx_o); end
    set_desc(1, 1'b1, 4'b0010, 8'd1, 8'd0); set_desc(3, 1'b1, 4'b1000, 8'd1, 8'd0); #1;
    vecs++; if (req_ready_o !== 4'b0010) begin errs++; $display("FAIL rstmid_regrant got %b want 0010", req_ready_o); end
    @(negedge clk_i); req_valid_i = '0; #1;
    vecs++; if (core_start_o !== 1'b1 || gnt_idx_o !== 2'd1 || core_nss_o !== 4'b0010) begin errs++; $display("FAIL rstmid_start got start=%b gnt=%0d nss=%b want 1/1/0010", core_start_o, gnt_idx_o, core_nss_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0; req_nss_i = '0; req_txcnt_i = '0; req_rxcnt_i = '0;
    tx_valid_i = '0; tx_data_i = '0; rx_ready_i = '0;
    core_tx_ready_i = 1'b0; core_rx_valid_i = 1'b0; core_rx_data_i = '0; core_done_i = 1'b0;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_len();
    test_surplus();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
